// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver with oversampling. It synchronises the serial input,
//   qualifies the start bit at its centre, and samples 8 data bits LSB-first
//   at mid-bit. It optionally checks an odd or even parity bit, and it checks
//   the stop bit. Each byte is presented with a one-cycle valid pulse and
//   error flags.
//
// Ports
//   baud_clk      in   oversampling clock (OVERSAMPLE x baud rate)
//   rst           in   asynchronous active-high reset
//   parity_i[1:0] in   0 none, 1 odd, 2 even, 3 none (latched per frame)
//   rx_i          in   serial input, idle high, asynchronous
//   data_o[7:0]   out  last received byte, held until next valid_o
//   valid_o       out  one-cycle pulse when data_o / error flags update
//   parity_err_o  out  parity mismatch on the flagged frame
//   frame_err_o   out  stop bit sampled low on the flagged frame
//   busy_o        out  receiver is inside a frame (FSM not idle)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic [1:0] parity_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_reg, state_next;
  logic             rx_meta_reg, rx_s_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [1:0]       par_mode_reg;
  logic             par_err_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             parity_err_reg;
  logic             frame_err_reg;

  logic             mid_tick;
  logic             use_parity;
  logic             par_expected;

  // The start bit is judged half a bit in; after that every full bit
  // period lands on the centre of the next bit.
  always_comb begin
    mid_tick     = (state_reg == START) ? (cnt_reg == HALF_M1) : (cnt_reg == LAST);
    use_parity   = (par_mode_reg == 2'd1) || (par_mode_reg == 2'd2);
    par_expected = (par_mode_reg == 2'd2) ? ^shift_reg : ~^shift_reg;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!rx_s_reg) state_next = START;
      START:     if (mid_tick) state_next = rx_s_reg ? IDLE : DATA;
      DATA:      if (mid_tick && (bit_cnt_reg == 3'd7))
                   state_next = use_parity ? PARITY : STOP;
      PARITY:    if (mid_tick) state_next = STOP;
      STOP:      if (mid_tick) state_next = rx_s_reg ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s_reg) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Synchroniser, counters and datapath
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg    <= 1'b1;
      rx_s_reg       <= 1'b1;
      cnt_reg        <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_mode_reg   <= '0;
      par_err_reg    <= 1'b0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
      valid_reg   <= 1'b0;

      // Restart the tick count on every state change and after each sample.
      if ((state_next != state_reg) || mid_tick) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            par_mode_reg <= parity_i;
            par_err_reg  <= 1'b0;
          end
        end
        START: begin
          if (mid_tick) bit_cnt_reg <= '0;
        end
        DATA: begin
          if (mid_tick) begin
            shift_reg   <= {rx_s_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        PARITY: begin
          if (mid_tick) par_err_reg <= rx_s_reg ^ par_expected;
        end
        STOP: begin
          if (mid_tick) begin
            valid_reg      <= 1'b1;
            data_reg       <= shift_reg;
            parity_err_reg <= use_parity & par_err_reg;
            frame_err_reg  <= ~rx_s_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o       = data_reg;
  assign valid_o      = valid_reg;
  assign parity_err_o = parity_err_reg;
  assign frame_err_o  = frame_err_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Bench for uart_rx at OVERSAMPLE = 16. Frames are built bit by bit from
//   the byte, the parity mode and the stop value. Expected bytes and flags
//   come from a frame-level model that uses popcount parity rules. A monitor
//   records every valid_o pulse with its cycle number.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] parity_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     c;
  } rec_t;

  rec_t rxq[$];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .baud_clk     (clk),
    .rst          (rst),
    .parity_i     (parity_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each cycle in which valid_o is high becomes one entry. A pulse that is
  // too wide therefore shows up as an extra frame.
  always @(negedge clk) begin
    if (valid_o) rxq.push_back('{data_o, parity_err_o, frame_err_o, cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the expected parity error for a frame.
  function automatic logic model_perr(input logic [7:0] d, input logic [1:0] mode, input logic p);
    logic want_p;
    want_p = 1'b0;
    if (mode == 2'd2) want_p = ($countones(d) % 2) == 1;   // total ones even
    if (mode == 2'd1) want_p = ($countones(d) % 2) == 0;   // total ones odd
    if (mode == 2'd1 || mode == 2'd2) return p != want_p;
    return 1'b0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame, starting and ending at a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic p,
                            input logic stop, input logic chg_par);
    rx_i = 1'b0;
    wait_cycles(OS);
    for (int b = 0; b < 8; b++) begin
      rx_i = d[b];
      if (chg_par && b == 3) parity_i = 2'd2;
      wait_cycles(OS);
    end
    if (has_par) begin
      rx_i = p;
      wait_cycles(OS);
    end
    rx_i = stop;
    wait_cycles(OS);
  endtask

  task automatic get_pulse(input string tag, output rec_t r, output logic ok);
    for (int i = 0; i < 64 && rxq.size() == 0; i++) @(negedge clk);
    ok = (rxq.size() != 0);
    check({tag, "_pulse_seen"}, {31'd0, ok}, 32'd1);
    r = '{8'h00, 1'b0, 1'b0, 0};
    if (ok) begin
      r = rxq.pop_front();
      $display("rx frame %s: data=%02h perr=%b ferr=%b cycle=%0d", tag, r.d, r.pe, r.fe, r.c);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    rec_t r;
    logic ok;
    get_pulse(tag, r, ok);
    if (ok) begin
      check({tag, "_data"}, {24'd0, r.d}, {24'd0, d});
      check({tag, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
    end
  endtask

  task automatic expect_no_pulse(input string tag);
    check({tag, "_extra_pulses"}, rxq.size(), 32'd0);
    rxq.delete();
  endtask

  initial begin
    rec_t r1, r2;
    logic ok1, ok2;
    logic [7:0] d;
    logic [1:0] mode;
    logic p, stop;

    rst = 1'b1;
    parity_i = 2'd0;
    rx_i = 1'b1;
    wait_cycles(4);

    // Reset state
    check("rst_data",  {24'd0, data_o}, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_perr",  {31'd0, parity_err_o}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    wait_cycles(4);

    // Plain frame, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_frame("a5_noparity", 8'hA5, 1'b0, 1'b0);
    wait_cycles(4);
    check("a5_busy_idle", {31'd0, busy_o}, 32'd0);
    expect_no_pulse("a5");

    // Even parity, correct then wrong parity bit
    parity_i = 2'd2;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_frame("even_ok", 8'h03, model_perr(8'h03, 2'd2, 1'b0), 1'b0);
    wait_cycles(8);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_frame("even_bad", 8'h03, model_perr(8'h03, 2'd2, 1'b1), 1'b0);
    wait_cycles(8);

    // Odd parity; parity_i switches to even mid-frame and must be ignored
    parity_i = 2'd1;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_frame("odd_midchg", 8'h01, model_perr(8'h01, 2'd1, 1'b0), 1'b0);
    parity_i = 2'd0;
    wait_cycles(8);
    expect_no_pulse("parity");

    // Stop bit low followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(40);
    check("brk_busy_held", {31'd0, busy_o}, 32'd1);
    check("brk_pulse_count", rxq.size(), 32'd1);
    expect_frame("brk", 8'h55, 1'b0, 1'b1);
    rx_i = 1'b1;
    wait_cycles(5);
    check("brk_busy_release", {31'd0, busy_o}, 32'd0);
    wait_cycles(200);
    expect_no_pulse("brk");

    // Start-bit glitch of 5 cycles
    rx_i = 1'b0;
    wait_cycles(5);
    check("glitch_busy_seen", {31'd0, busy_o}, 32'd1);
    rx_i = 1'b1;
    for (int i = 0; i < 8 && busy_o; i++) @(negedge clk);
    check("glitch_busy_drop", {31'd0, busy_o}, 32'd0);
    wait_cycles(200);
    expect_no_pulse("glitch");

    // Random frames checked against the model
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      p    = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      parity_i = mode;
      send_frame(d, (mode == 2'd1 || mode == 2'd2), p, stop, 1'b0);
      rx_i = 1'b1;
      expect_frame($sformatf("rand%0d_m%0d", k, mode), d, model_perr(d, mode, p), ~stop);
      wait_cycles(20);
    end
    parity_i = 2'd0;
    expect_no_pulse("rand");

    // Back-to-back frames, then a third frame reset during bit 4
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    rx_i = 1'b0;
    wait_cycles(OS);
    for (int b = 0; b < 4; b++) begin
      rx_i = b[0];
      wait_cycles(OS);
    end
    rx_i = 1'b1;
    wait_cycles(OS / 2);
    rst = 1'b1;
    wait_cycles(2);
    check("midrst_data",  {24'd0, data_o}, 32'h0);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_perr",  {31'd0, parity_err_o}, 32'd0);
    check("midrst_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("midrst_busy",  {31'd0, busy_o}, 32'd0);
    rx_i = 1'b1;
    rst = 1'b0;

    get_pulse("b2b_first", r1, ok1);
    get_pulse("b2b_second", r2, ok2);
    if (ok1) check("b2b_first_data", {24'd0, r1.d}, 32'h12);
    if (ok2) check("b2b_second_data", {24'd0, r2.d}, 32'hEF);
    if (ok1 && ok2) check("b2b_spacing", 32'(r2.c - r1.c), 32'd160);
    wait_cycles(300);
    expect_no_pulse("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
